// File: rtl/rt_access_ctrl_if.sv
// Host-side request bus for rt_access_ctrl.
//   master : drives req_i, we_i, target_i, lim_i, addr_i, wdata_i;
//            receives gnt_o, rvalid_o, rdata_o, busy_o
//   slave  : the controller side of the same signals
// Signal names keep the controller's _i/_o view so they match its datasheet.
interface rt_access_ctrl_if #(
    parameter int Nr = 4,
    parameter int Nb = 32
);
    localparam int AW = $clog2(Nb);

    logic          req_i;
    logic          gnt_o;
    logic          we_i;
    logic [1:0]    target_i;
    logic          lim_i;
    logic [AW-1:0] addr_i;
    logic [Nr-1:0] wdata_i;
    logic          rvalid_o;
    logic [Nr-1:0] rdata_o;
    logic          busy_o;

    modport master (
        output req_i, we_i, target_i, lim_i, addr_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o, busy_o
    );

    modport slave (
        input  req_i, we_i, target_i, lim_i, addr_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o, busy_o
    );
endinterface

// File: rtl/rt_access_ctrl.sv
// Sequencing controller for the LiM racetrack memory unit.
// Takes one host request at a time (write / data read / LiM read) and plays
// out the word-line, write-enable, two-phase clock-current and read-current
// pattern the racetrack array needs. All array-side pins are registered.
// Ports:
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   host                 request bus (slave side), see rt_access_ctrl_if
//   word_lines_o         one-hot word-line select
//   write_i_*_o          per-target write data (0 unless that target is written)
//   write_en_*_o         per-target write enable
//   current_s/m_*_o      slave / master phase clock currents
//   Bz_s_o, Bz_m_o       perpendicular field during the LiM phases
//   read_current_o       array read enable
//   out_select_o         array output mux, 1 = LiM result
//   r_data_i             array read output, sampled at the end of RD
module rt_access_ctrl #(
    parameter int Nr = 4,
    parameter int Nb = 32,
    parameter int Np = 8
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    rt_access_ctrl_if.slave host,
    output logic [Nb-1:0] word_lines_o,
    output logic [Nr-1:0] write_i_data_o,
    output logic [Nr-1:0] write_i_mask_o,
    output logic [Nr-1:0] write_i_program_o,
    output logic          write_en_data_o,
    output logic          write_en_mask_o,
    output logic          write_en_program_o,
    output logic          current_s_data_o,
    output logic          current_s_mask_o,
    output logic          current_s_program_o,
    output logic          current_s_lim_o,
    output logic          current_m_data_o,
    output logic          current_m_mask_o,
    output logic          current_m_program_o,
    output logic          current_m_lim_o,
    output logic          Bz_s_o,
    output logic          Bz_m_o,
    output logic          read_current_o,
    output logic          out_select_o,
    input  logic [Nr-1:0] r_data_i
);
    localparam int AW = $clog2(Nb);

    // Port decode lives in the array; the port count only has to divide the
    // track length for the geometry to make sense.
    if ((Nb % Np) != 0) begin : g_geometry_mismatch
        localparam int GEOMETRY_MISMATCH = 1;
    end

    typedef enum logic [2:0] {IDLE, WR_S, WR_M, LM_S, LM_M, RD} state_t;

    state_t        state_reg;
    logic [1:0]    tgt_reg;
    logic          lim_reg;
    logic [AW-1:0] addr_reg;
    logic [Nr-1:0] wdata_reg;
    logic          rvalid_reg;
    logic [Nr-1:0] rdata_reg;

    // Per-target array controls, index 0 data, 1 mask, 2 program.
    logic [2:0]          wen_reg;
    logic [2:0]          cur_s_reg;
    logic [2:0]          cur_m_reg;
    logic [2:0][Nr-1:0]  wr_data_reg;

    // In IDLE the first phase is launched straight from the host fields, so
    // the source of target/address/data depends on the current state.
    logic [1:0]          tgt_src;
    logic [AW-1:0]       addr_src;
    logic [Nr-1:0]       wdata_src;
    logic [2:0]          tgt_hot;
    logic [Nb-1:0]       wl_hot;
    logic [2:0][Nr-1:0]  wr_data_next;

    always_comb begin
        tgt_src   = tgt_reg;
        addr_src  = addr_reg;
        wdata_src = wdata_reg;
        if (state_reg == IDLE) begin
            tgt_src   = host.target_i;
            addr_src  = host.addr_i;
            wdata_src = host.wdata_i;
        end
        // Reserved target 3 decodes to no target at all.
        tgt_hot = (tgt_src == 2'd3) ? 3'b000 : (3'b001 << tgt_src);
        wl_hot  = {{(Nb-1){1'b0}}, 1'b1} << addr_src;
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_wr_data
        assign wr_data_next[gi] = tgt_hot[gi] ? wdata_src : '0;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg      <= IDLE;
            tgt_reg        <= '0;
            lim_reg        <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            rvalid_reg     <= 1'b0;
            rdata_reg      <= '0;
            wen_reg        <= '0;
            cur_s_reg      <= '0;
            cur_m_reg      <= '0;
            wr_data_reg    <= '0;
            word_lines_o   <= '0;
            current_s_lim_o <= 1'b0;
            current_m_lim_o <= 1'b0;
            Bz_s_o         <= 1'b0;
            Bz_m_o         <= 1'b0;
            read_current_o <= 1'b0;
            out_select_o   <= 1'b0;
        end else begin
            // Every array pin is a one-cycle pulse for the phase entered next;
            // anything not set below returns to 0.
            rvalid_reg     <= 1'b0;
            wen_reg        <= '0;
            cur_s_reg      <= '0;
            cur_m_reg      <= '0;
            wr_data_reg    <= '0;
            word_lines_o   <= '0;
            current_s_lim_o <= 1'b0;
            current_m_lim_o <= 1'b0;
            Bz_s_o         <= 1'b0;
            Bz_m_o         <= 1'b0;
            read_current_o <= 1'b0;
            out_select_o   <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (host.req_i) begin
                        tgt_reg      <= host.target_i;
                        lim_reg      <= host.lim_i;
                        addr_reg     <= host.addr_i;
                        wdata_reg    <= host.wdata_i;
                        word_lines_o <= wl_hot;
                        if (host.we_i) begin
                            state_reg   <= WR_S;
                            wen_reg     <= tgt_hot;
                            cur_s_reg   <= tgt_hot;
                            wr_data_reg <= wr_data_next;
                        end else if (host.lim_i) begin
                            state_reg       <= LM_S;
                            current_s_lim_o <= 1'b1;
                            Bz_s_o          <= 1'b1;
                        end else begin
                            state_reg      <= RD;
                            read_current_o <= 1'b1;
                        end
                    end
                end
                WR_S: begin
                    state_reg    <= WR_M;
                    word_lines_o <= wl_hot;
                    wen_reg      <= tgt_hot;
                    cur_m_reg    <= tgt_hot;
                    wr_data_reg  <= wr_data_next;
                end
                WR_M: begin
                    state_reg  <= IDLE;
                    rvalid_reg <= 1'b1;
                end
                LM_S: begin
                    state_reg       <= LM_M;
                    word_lines_o    <= wl_hot;
                    current_m_lim_o <= 1'b1;
                    Bz_m_o          <= 1'b1;
                end
                LM_M: begin
                    state_reg      <= RD;
                    word_lines_o   <= wl_hot;
                    read_current_o <= 1'b1;
                    out_select_o   <= lim_reg;
                end
                RD: begin
                    state_reg  <= IDLE;
                    rdata_reg  <= r_data_i;
                    rvalid_reg <= 1'b1;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Grant is masked by reset so nothing is accepted while the unit is held.
    assign host.gnt_o    = host.req_i && (state_reg == IDLE) && rstn_i;
    assign host.busy_o   = (state_reg != IDLE);
    assign host.rvalid_o = rvalid_reg;
    assign host.rdata_o  = rdata_reg;

    assign write_en_data_o     = wen_reg[0];
    assign write_en_mask_o     = wen_reg[1];
    assign write_en_program_o  = wen_reg[2];
    assign current_s_data_o    = cur_s_reg[0];
    assign current_s_mask_o    = cur_s_reg[1];
    assign current_s_program_o = cur_s_reg[2];
    assign current_m_data_o    = cur_m_reg[0];
    assign current_m_mask_o    = cur_m_reg[1];
    assign current_m_program_o = cur_m_reg[2];
    assign write_i_data_o      = wr_data_reg[0];
    assign write_i_mask_o      = wr_data_reg[1];
    assign write_i_program_o   = wr_data_reg[2];
endmodule

// File: tb/tb_rt_access_ctrl.sv
module tb_rt_access_ctrl;
    localparam int Nr = 4;
    localparam int Nb = 32;

    logic clk = 1'b0;
    logic rstn_i;
    always #5 clk = ~clk;

    rt_access_ctrl_if #(.Nr(Nr), .Nb(Nb)) host ();

    logic [Nb-1:0] word_lines_o;
    logic [Nr-1:0] write_i_data_o, write_i_mask_o, write_i_program_o;
    logic write_en_data_o, write_en_mask_o, write_en_program_o;
    logic current_s_data_o, current_s_mask_o, current_s_program_o, current_s_lim_o;
    logic current_m_data_o, current_m_mask_o, current_m_program_o, current_m_lim_o;
    logic Bz_s_o, Bz_m_o, read_current_o, out_select_o;
    logic [Nr-1:0] r_data_i;

    rt_access_ctrl #(.Nr(Nr), .Nb(Nb), .Np(8)) dut (
        .clk_i               (clk),
        .rstn_i              (rstn_i),
        .host                (host),
        .word_lines_o        (word_lines_o),
        .write_i_data_o      (write_i_data_o),
        .write_i_mask_o      (write_i_mask_o),
        .write_i_program_o   (write_i_program_o),
        .write_en_data_o     (write_en_data_o),
        .write_en_mask_o     (write_en_mask_o),
        .write_en_program_o  (write_en_program_o),
        .current_s_data_o    (current_s_data_o),
        .current_s_mask_o    (current_s_mask_o),
        .current_s_program_o (current_s_program_o),
        .current_s_lim_o     (current_s_lim_o),
        .current_m_data_o    (current_m_data_o),
        .current_m_mask_o    (current_m_mask_o),
        .current_m_program_o (current_m_program_o),
        .current_m_lim_o     (current_m_lim_o),
        .Bz_s_o              (Bz_s_o),
        .Bz_m_o              (Bz_m_o),
        .read_current_o      (read_current_o),
        .out_select_o        (out_select_o),
        .r_data_i            (r_data_i)
    );

    // Racetrack array model: a word is committed in the master phase; the
    // LiM result of a word is data XOR mask.
    logic [Nr-1:0] data_mem [Nb] = '{default: '0};
    logic [Nr-1:0] mask_mem [Nb] = '{default: '0};
    logic [Nr-1:0] prog_mem [Nb] = '{default: '0};

    always @(posedge clk) begin
        for (int i = 0; i < Nb; i++) begin
            if (word_lines_o[i]) begin
                if (write_en_data_o && current_m_data_o)       data_mem[i] <= write_i_data_o;
                if (write_en_mask_o && current_m_mask_o)       mask_mem[i] <= write_i_mask_o;
                if (write_en_program_o && current_m_program_o) prog_mem[i] <= write_i_program_o;
            end
        end
    end

    always_comb begin
        r_data_i = '0;
        if (read_current_o) begin
            for (int i = 0; i < Nb; i++) begin
                if (word_lines_o[i])
                    r_data_i = out_select_o ? (data_mem[i] ^ mask_mem[i]) : data_mem[i];
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input logic we, input logic [1:0] tgt, input logic lim,
                           input logic [4:0] addr, input logic [3:0] wd);
        host.req_i    = 1'b1;
        host.we_i     = we;
        host.target_i = tgt;
        host.lim_i    = lim;
        host.addr_i   = addr;
        host.wdata_i  = wd;
    endtask

    // Issue one request from IDLE and check gnt, rvalid latency and read data.
    task automatic do_txn(input string tag, input logic we, input logic [1:0] tgt,
                          input logic lim, input logic [4:0] addr, input logic [3:0] wd,
                          input int lat, input logic [3:0] exp_rd);
        step();
        set_req(we, tgt, lim, addr, wd);
        settle();
        chk({tag, "_gnt"}, 32'(host.gnt_o), 32'd1);
        step();
        host.req_i = 1'b0;
        for (int c = 1; c < lat; c++) begin
            if (c > 1) step();
            settle();
            chk({tag, "_no_early_rvalid"}, 32'(host.rvalid_o), 32'd0);
        end
        step();
        settle();
        chk({tag, "_rvalid"}, 32'(host.rvalid_o), 32'd1);
        if (!we) chk({tag, "_rdata"}, 32'(host.rdata_o), 32'(exp_rd));
    endtask

    function automatic logic [31:0] all_array_pins();
        return 32'({write_en_data_o, write_en_mask_o, write_en_program_o,
                    current_s_data_o, current_s_mask_o, current_s_program_o, current_s_lim_o,
                    current_m_data_o, current_m_mask_o, current_m_program_o, current_m_lim_o,
                    Bz_s_o, Bz_m_o, read_current_o, out_select_o,
                    |write_i_data_o, |write_i_mask_o, |write_i_program_o, |word_lines_o});
    endfunction

    typedef struct {
        logic       we;
        logic [4:0] addr;
        logic [3:0] wd;
        int         lat;
        logic [3:0] exp_rd;
    } op_t;

    op_t ops [4];

    initial begin
        // ---------------- reset with arbitrary inputs ----------------
        rstn_i = 1'b0;
        set_req(1'b1, 2'd1, 1'b1, 5'd9, 4'h7);
        step(); step();
        chk("rst_gnt", 32'(host.gnt_o), 32'd0);
        chk("rst_busy", 32'(host.busy_o), 32'd0);
        chk("rst_rvalid", 32'(host.rvalid_o), 32'd0);
        chk("rst_rdata", 32'(host.rdata_o), 32'd0);
        chk("rst_array_pins", all_array_pins(), 32'd0);
        host.req_i = 1'b0;
        rstn_i = 1'b1;
        settle();
        chk("post_rst_gnt_idle", 32'(host.gnt_o), 32'd0);

        // ---------------- data write addr 5 = 0xA ----------------
        step();
        set_req(1'b1, 2'd0, 1'b0, 5'd5, 4'hA);
        settle();
        chk("wr_gnt", 32'(host.gnt_o), 32'd1);
        step();
        host.req_i = 1'b0;
        settle();
        chk("wr_c1_wl", word_lines_o, 32'h20);
        chk("wr_c1_en", 32'(write_en_data_o), 32'd1);
        chk("wr_c1_cur_s", 32'(current_s_data_o), 32'd1);
        chk("wr_c1_cur_m", 32'(current_m_data_o), 32'd0);
        chk("wr_c1_wdata", 32'(write_i_data_o), 32'hA);
        chk("wr_c1_other_wdata", 32'({write_i_mask_o, write_i_program_o}), 32'd0);
        chk("wr_c1_busy", 32'(host.busy_o), 32'd1);
        step(); settle();
        chk("wr_c2_cur_m", 32'(current_m_data_o), 32'd1);
        chk("wr_c2_cur_s", 32'(current_s_data_o), 32'd0);
        chk("wr_c2_wl", word_lines_o, 32'h20);
        chk("wr_c2_rvalid", 32'(host.rvalid_o), 32'd0);
        step(); settle();
        chk("wr_c3_rvalid", 32'(host.rvalid_o), 32'd1);
        chk("wr_c3_idle_pins", all_array_pins(), 32'd0);
        chk("wr_c3_busy", 32'(host.busy_o), 32'd0);

        // ---------------- data read addr 5 ----------------
        step();
        set_req(1'b0, 2'd0, 1'b0, 5'd5, 4'h0);
        settle();
        chk("rd_gnt", 32'(host.gnt_o), 32'd1);
        step();
        host.req_i = 1'b0;
        settle();
        chk("rd_c1_read_current", 32'(read_current_o), 32'd1);
        chk("rd_c1_out_select", 32'(out_select_o), 32'd0);
        chk("rd_c1_wl", word_lines_o, 32'h20);
        step(); settle();
        chk("rd_c2_rvalid", 32'(host.rvalid_o), 32'd1);
        chk("rd_c2_rdata", 32'(host.rdata_o), 32'hA);

        // ---------------- mask write addr 31 = 0x3 ----------------
        step();
        set_req(1'b1, 2'd1, 1'b0, 5'd31, 4'h3);
        settle();
        chk("mwr_gnt", 32'(host.gnt_o), 32'd1);
        step();
        host.req_i = 1'b0;
        settle();
        chk("mwr_c1_wl", word_lines_o, 32'h8000_0000);
        chk("mwr_c1_en", 32'({write_en_data_o, write_en_mask_o, write_en_program_o}), 32'b010);
        chk("mwr_c1_cur_s", 32'({current_s_data_o, current_s_mask_o, current_s_program_o}), 32'b010);
        chk("mwr_c1_wdata", 32'({write_i_data_o, write_i_mask_o, write_i_program_o}), 32'h030);
        step(); settle();
        chk("mwr_c2_cur_m", 32'({current_m_data_o, current_m_mask_o, current_m_program_o}), 32'b010);
        chk("mwr_c2_cur_s", 32'(current_s_mask_o), 32'd0);
        step(); settle();
        chk("mwr_c3_rvalid", 32'(host.rvalid_o), 32'd1);
        chk("rdata_kept_after_write", 32'(host.rdata_o), 32'hA);

        // ---------------- LiM read addr 31: 0 ^ 3 = 3 ----------------
        step();
        set_req(1'b0, 2'd0, 1'b1, 5'd31, 4'h0);
        settle();
        chk("lim_gnt", 32'(host.gnt_o), 32'd1);
        step();
        host.req_i = 1'b0;
        settle();
        chk("lim_c1_s", 32'({current_s_lim_o, Bz_s_o, current_m_lim_o, Bz_m_o, read_current_o}), 32'b11000);
        chk("lim_c1_wl", word_lines_o, 32'h8000_0000);
        step(); settle();
        chk("lim_c2_m", 32'({current_s_lim_o, Bz_s_o, current_m_lim_o, Bz_m_o, read_current_o}), 32'b00110);
        step(); settle();
        chk("lim_c3_rd", 32'({current_s_lim_o, current_m_lim_o, read_current_o, out_select_o}), 32'b0011);
        chk("lim_c3_rvalid", 32'(host.rvalid_o), 32'd0);
        step(); settle();
        chk("lim_c4_rvalid", 32'(host.rvalid_o), 32'd1);
        chk("lim_c4_rdata", 32'(host.rdata_o), 32'h3);

        // ---------------- reserved target write ----------------
        step();
        set_req(1'b1, 2'd3, 1'b0, 5'd4, 4'hF);
        settle();
        chk("res_gnt", 32'(host.gnt_o), 32'd1);
        step();
        host.req_i = 1'b0;
        settle();
        chk("res_c1_quiet", 32'({write_en_data_o, write_en_mask_o, write_en_program_o,
                                 current_s_data_o, current_s_mask_o, current_s_program_o}), 32'd0);
        step(); settle();
        chk("res_c2_quiet", 32'({current_m_data_o, current_m_mask_o, current_m_program_o,
                                 write_en_data_o, write_en_mask_o, write_en_program_o}), 32'd0);
        chk("res_c2_busy", 32'(host.busy_o), 32'd1);
        step(); settle();
        chk("res_c3_rvalid", 32'(host.rvalid_o), 32'd1);

        // ---------------- back-to-back, req held high ----------------
        ops[0] = '{we: 1'b1, addr: 5'd2, wd: 4'h5, lat: 3, exp_rd: 4'h0};
        ops[1] = '{we: 1'b0, addr: 5'd2, wd: 4'h0, lat: 2, exp_rd: 4'h5};
        ops[2] = '{we: 1'b1, addr: 5'd3, wd: 4'h9, lat: 3, exp_rd: 4'h0};
        ops[3] = '{we: 1'b0, addr: 5'd3, wd: 4'h0, lat: 2, exp_rd: 4'h9};
        step();
        set_req(ops[0].we, 2'd0, 1'b0, ops[0].addr, ops[0].wd);
        settle();
        chk("b2b_gnt0", 32'(host.gnt_o), 32'd1);
        for (int i = 0; i < 4; i++) begin
            for (int c = 1; c < ops[i].lat; c++) begin
                step(); settle();
                chk("b2b_busy_no_gnt", 32'(host.gnt_o), 32'd0);
            end
            step();
            if (i < 3) set_req(ops[i+1].we, 2'd0, 1'b0, ops[i+1].addr, ops[i+1].wd);
            else       host.req_i = 1'b0;
            settle();
            chk("b2b_rvalid", 32'(host.rvalid_o), 32'd1);
            if (!ops[i].we) chk("b2b_rdata", 32'(host.rdata_o), 32'(ops[i].exp_rd));
            if (i < 3) chk("b2b_gnt_with_rvalid", 32'(host.gnt_o), 32'd1);
        end

        // ---------------- reset during WR_M ----------------
        step();
        set_req(1'b1, 2'd0, 1'b0, 5'd7, 4'hF);
        settle();
        chk("rstwr_gnt", 32'(host.gnt_o), 32'd1);
        step();
        host.req_i = 1'b0;
        step(); settle();
        chk("rstwr_in_wr_m", 32'(current_m_data_o), 32'd1);
        rstn_i = 1'b0;
        settle();
        chk("rstwr_pins_dropped", all_array_pins(), 32'd0);
        chk("rstwr_busy", 32'(host.busy_o), 32'd0);
        chk("rstwr_rdata_cleared", 32'(host.rdata_o), 32'd0);
        step();
        rstn_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("rstwr_no_rvalid", 32'(host.rvalid_o), 32'd0);
            step();
        end
        do_txn("after_rst_rd7", 1'b0, 2'd0, 1'b0, 5'd7, 4'h0, 2, 4'h0);
        do_txn("after_rst_wr7", 1'b1, 2'd0, 1'b0, 5'd7, 4'hC, 3, 4'h0);
        do_txn("after_rst_rd7b", 1'b0, 2'd0, 1'b0, 5'd7, 4'h0, 2, 4'hC);
        do_txn("prog_wr", 1'b1, 2'd2, 1'b0, 5'd0, 4'h6, 3, 4'h0);
        chk("prog_mem_written", 32'(prog_mem[0]), 32'h6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rt_access_ctrl.md
# rt_access_ctrl

Sequencing controller for the 4-track, 32-bit, 8-port LiM racetrack memory unit. It accepts one request at a time from a simple req/gnt host interface: a data/mask/program write, a standard data read, or a LiM (logic) read. It converts each request into the cycle-exact word-line, write-enable, two-phase pNML clock-current and read-current pattern the array needs. It sits between the core's memory-side logic and the racetrack array and owns every array control pin.

## Interface
Parameters:
- Nr, 4, number of racetracks (bits per access)
- Nb, 32, word lines per track
- Np, 8, ports per track (informational; port decode stays inside the array)

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous reset, active-low
- req_i  in  1  host request valid
- gnt_o  out  1  request accepted this cycle (combinational: req_i && state==IDLE)
- we_i  in  1  1 = write, 0 = read
- target_i  in  2  write target: 0 data, 1 mask, 2 program, 3 reserved
- lim_i  in  1  read only: 1 = LiM read, 0 = data read
- addr_i  in  $clog2(Nb)  word-line index
- wdata_i  in  Nr  write data
- rvalid_o  out  1  one-cycle completion pulse (reads and writes)
- rdata_o  out  Nr  read data, valid with rvalid_o on reads
- busy_o  out  1  state != IDLE
- word_lines_o  out  Nb  one-hot word-line select to array
- write_i_data_o / write_i_mask_o / write_i_program_o  out  Nr each  write data to array
- write_en_data_o / write_en_mask_o / write_en_program_o  out  1 each  array write enables
- current_s_{data,mask,program,lim}_o  out  1 each  slave-phase clock current
- current_m_{data,mask,program,lim}_o  out  1 each  master-phase clock current
- Bz_s_o, Bz_m_o  out  1 each  perpendicular field for LiM phases
- read_current_o  out  1  array read enable
- out_select_o  out  1  array output mux: 1 LiM, 0 data
- r_data_i  in  Nr  array read output

## Operation
- FSM states: IDLE, WR_S, WR_M, LM_S, LM_M, RD.
- IDLE: on req_i, assert gnt_o. Latch we_i, target_i, lim_i, addr_i and wdata_i into request registers. Next state:
  - write → WR_S
  - read with lim_i=0 → RD
  - read with lim_i=1 → LM_S
- WR_S:
  - word_lines_o = onehot(addr); write_i_<tgt>_o = wdata; write_en_<tgt>_o=1; current_s_<tgt>_o=1.
  - Next state WR_M.
- WR_M:
  - Same word line, write data and enable as WR_S; current_m_<tgt>_o=1; current_s_<tgt>_o=0.
  - Next state IDLE; rvalid_o pulses in the following cycle.
- Reserved target (3): the FSM traverses WR_S and WR_M with all write enables and currents low, and the write is still acknowledged.
- LM_S: word_lines_o = onehot(addr); current_s_lim_o=1; Bz_s_o=1. Next state LM_M.
- LM_M: word_lines_o = onehot(addr); current_m_lim_o=1; Bz_m_o=1. Next state RD.
- RD:
  - word_lines_o = onehot(addr); read_current_o=1; out_select_o = latched lim.
  - r_data_i is sampled into rdata_o at the end of the cycle; rvalid_o pulses in the next cycle. Next state IDLE.
- write_i_*_o for targets other than the latched target are driven 0.
- All array-side outputs are registered, so they are glitch-free. Every output is 0 in IDLE except write data, which is also 0 in IDLE.
- rdata_o holds its last read value until the next read completes. A write does not change rdata_o.
- Only one request is in flight at a time. The host must hold the request fields stable only in the gnt_o cycle.

## Timing
- Reset (asynchronous, any state): state=IDLE; every output is 0, including rdata_o, rvalid_o, word_lines_o, all currents, Bz and enables. An in-flight request is dropped with no rvalid_o.
- Latency from the gnt cycle (cycle 0) to the rvalid_o cycle:
  - write: 3
  - data read: 2
  - LiM read: 4
- The rvalid_o cycle is an IDLE cycle, so a new request can be granted in the same cycle. This gives a throughput of one write per 3 cycles, one data read per 2, one LiM read per 4.
- The s and m currents are never high together. Each is exactly one cycle wide.
- word_lines_o is one-hot or zero, never multi-hot.
- req_i outside IDLE: gnt_o=0; the request waits.

## Test plan
- Reset: drive arbitrary inputs while rstn_i=0 → all outputs 0, gnt_o follows req_i only after release.
- Data write addr=5, wdata=4'hA, target=0:
  - cycle 1: word_lines_o=32'h20, write_en_data_o=1, current_s_data_o=1.
  - cycle 2: current_m_data_o=1.
  - cycle 3: rvalid_o=1.
- Data read addr=5 against the racetrack array model → rvalid_o in cycle 2 with rdata_o=4'hA, out_select_o=0 during RD.
- Mask write addr=31, wdata=4'h3, then LiM read addr=31:
  - write: only mask enable and currents toggle.
  - read: LM_S, LM_M and RD are each one cycle, out_select_o=1 in RD, rvalid_o in cycle 4 with the array LiM value.
- Back-to-back: req_i held high with alternating write/read → each gnt coincides with the previous rvalid_o, and there are no idle bubbles.
- rstn_i asserted during WR_M → all currents and enables drop immediately, no rvalid_o, and the next request is processed normally.
